// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Round-robin arbiter between the CPU bus port (A) and the
//               game-logic updater (B) for a bank of memory-mapped game
//               registers. It decodes the address to a one-hot select, runs a
//               select/ready handshake with a timeout, and returns read data
//               plus a one-cycle ack to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int N_REGS    = 8,
  parameter int ADDR_W    = 3,
  parameter int DATA_SIZE = 6,
  parameter int TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_SIZE-1:0]   a_wdata,
  output logic                   a_ack,
  output logic                   a_err,
  output logic [31:0]            a_rdata,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_SIZE-1:0]   b_wdata,
  output logic                   b_ack,
  output logic                   b_err,
  output logic [31:0]            b_rdata,
  output logic [N_REGS-1:0]      reg_sel,
  output logic                   reg_we,
  output logic [DATA_SIZE-1:0]   reg_wdata,
  input  logic [N_REGS-1:0]      reg_ready,
  input  logic [N_REGS*32-1:0]   reg_rdata
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int                 c_CNT_W    = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_tmo_last = c_CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]    c_n_regs   = (ADDR_W + 1)'(N_REGS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_gnt_b;   // granted requester: 0 = A, 1 = B
  logic                 r_last_b;  // last completed grant: 0 = A, 1 = B
  logic                 r_abort;   // granted requester dropped req mid-access
  logic [ADDR_W-1:0]    r_addr;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_gnt_b;
  logic                 w_gnt_we;
  logic [ADDR_W-1:0]    w_gnt_addr;
  logic [DATA_SIZE-1:0] w_gnt_wdata;
  logic                 w_gnt_oor;
  logic [N_REGS-1:0]    w_gnt_sel;
  logic                 w_rdy;
  logic [31:0]          w_rword;
  logic                 w_timeout;
  logic                 w_req_g;
  logic [31:0]          w_resp_data;

  // Round-robin pick: a tie goes to whoever did not win last time.
  always_comb begin
    w_gnt_b = b_req;
    if (a_req && b_req) begin
      w_gnt_b = ~r_last_b;
    end
  end

  assign w_gnt_we    = w_gnt_b ? b_we    : a_we;
  assign w_gnt_addr  = w_gnt_b ? b_addr  : a_addr;
  assign w_gnt_wdata = w_gnt_b ? b_wdata : a_wdata;
  assign w_gnt_oor   = ({1'b0, w_gnt_addr} >= c_n_regs);

  // One-hot decode of the address about to be granted.
  always_comb begin
    w_gnt_sel = '0;
    for (int i = 0; i < N_REGS; i++) begin
      w_gnt_sel[i] = (w_gnt_addr == ADDR_W'(i));
    end
  end

  // Pick ready and read word of the register under access.
  always_comb begin
    w_rdy   = 1'b0;
    w_rword = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (r_addr == ADDR_W'(i)) begin
        w_rdy   = reg_ready[i];
        w_rword = reg_rdata[32*i +: 32];
      end
    end
  end

  assign w_timeout   = (r_cnt == c_tmo_last);
  assign w_req_g     = r_gnt_b ? b_req : a_req;
  assign w_resp_data = w_rdy ? w_rword : 32'h0;

  // Arbitration / access FSM with registered bank strobes and responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_gnt_b   <= 1'b0;
      r_last_b  <= 1'b1;
      r_abort   <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
      a_ack     <= 1'b0;
      a_err     <= 1'b0;
      a_rdata   <= '0;
      b_ack     <= 1'b0;
      b_err     <= 1'b0;
      b_rdata   <= '0;
      reg_sel   <= '0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (a_req || b_req) begin
            r_gnt_b <= w_gnt_b;
            r_addr  <= w_gnt_addr;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            if (w_gnt_oor) begin
              // No bank access for an address outside the bank.
              r_state <= S_RESP;
              if (w_gnt_b) begin
                b_ack   <= 1'b1;
                b_err   <= 1'b1;
                b_rdata <= '0;
              end else begin
                a_ack   <= 1'b1;
                a_err   <= 1'b1;
                a_rdata <= '0;
              end
            end else begin
              r_state   <= S_ACCESS;
              reg_sel   <= w_gnt_sel;
              reg_we    <= w_gnt_we;
              reg_wdata <= w_gnt_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (w_rdy || w_timeout) begin
            r_state <= S_RESP;
            reg_sel <= '0;
            reg_we  <= 1'b0;
            // A requester that walked away gets no response at all.
            if (w_req_g && !r_abort) begin
              if (r_gnt_b) begin
                b_ack   <= 1'b1;
                b_err   <= ~w_rdy;
                b_rdata <= w_resp_data;
              end else begin
                a_ack   <= 1'b1;
                a_err   <= ~w_rdy;
                a_rdata <= w_resp_data;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_req_g) begin
              r_abort <= 1'b1;
            end
          end
        end
        S_RESP: begin
          r_last_b <= r_gnt_b;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
